// File: rtl/e_mdu_ctrl_pkg.sv
// Shared MDU definitions: op encodings, default latencies, FSM states, op-class helpers.
// No logic of its own; imported by the controller and the arithmetic core.
package e_mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational multiply/divide core: 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU.
// Zero latency, no flow control; div_zero flags a divide op with a zero divisor.
module e_mdu_arith
  import e_mdu_ctrl_pkg::*;
(
  input  logic [3:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic        sgn;
  logic        q_neg;
  logic        r_neg;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    sgn      = (MDUOp == MDU_MULT) || (MDUOp == MDU_DIV);
    div_zero = is_div_op(MDUOp) && (SrcB == 32'd0);

    // Low 64 bits of the product of extended operands equal the true signed/unsigned product.
    a_ext = {{32{sgn & SrcA[31]}}, SrcA};
    b_ext = {{32{sgn & SrcB[31]}}, SrcB};
    prod  = a_ext * b_ext;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out naturally as 0x80000000.
    a_mag   = (sgn & SrcA[31]) ? -SrcA : SrcA;
    b_mag   = (sgn & SrcB[31]) ? -SrcB : SrcB;
    divisor = (SrcB == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    q_neg   = sgn & (SrcA[31] ^ SrcB[31]);
    r_neg   = sgn & SrcA[31];

    if (is_mul_op(MDUOp)) begin
      {res_hi, res_lo} = prod;
    end else if (is_div_op(MDUOp)) begin
      res_lo = q_neg ? -q_mag : q_mag;
      res_hi = r_neg ? -r_mag : r_mag;
    end
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage MDU scheduler: holds a mul/div for MULT_CYCLES/DIV_CYCLES with Busy high, then commits HI/LO.
// Start is dropped while Busy or flushed; MTHI/MTLO write in one cycle, MFHI/MFLO read HI/LO directly.
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] res_q;
  logic        zero_q;
  logic        accept;
  logic        load;
  logic        commit;
  logic [31:0] ar_hi;
  logic [31:0] ar_lo;
  logic        ar_zero;

  e_mdu_arith u_arith (
    .MDUOp   (MDUOp),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .res_hi  (ar_hi),
    .res_lo  (ar_lo),
    .div_zero(ar_zero)
  );

  assign Busy   = (state_q == ST_RUN);
  assign accept = Start & ~Flush & ~Busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (is_mul_op(MDUOp) || is_div_op(MDUOp))) begin
          load    = 1'b1;
          state_d = ST_RUN;
          cnt_d   = is_div_op(MDUOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        res_q  <= {ar_hi, ar_lo};
        zero_q <= ar_zero;
      end
      // Divide-by-zero still burns the full latency but leaves HI/LO untouched.
      if (commit && !zero_q) begin
        {HI, LO} <= res_q;
      end else if (accept && (MDUOp == MDU_MTHI)) begin
        HI <= SrcA;
      end else if (accept && (MDUOp == MDU_MTLO)) begin
        LO <= SrcA;
      end
    end
  end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: directed cases plus randomized ops against a plain-arithmetic HI/LO model.
module tb_e_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  MDUOp = 4'd0;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic        Flush = 1'b0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .Start(Start),
    .MDUOp(MDUOp),
    .SrcA (SrcA),
    .SrcB (SrcB),
    .Flush(Flush),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_cycles(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return MC;
    if (op == 4'd3 || op == 4'd4) return DC;
    return 0;
  endfunction

  // Architectural effect of one accepted op, from the instruction definitions.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: begin up = longint'(sa * sb); m_hi = up[63:32]; m_lo = up[31:0]; end
      4'd2: begin up = ua * ub;           m_hi = up[63:32]; m_lo = up[31:0]; end
      4'd3: if (b != 0) begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      4'd4: if (b != 0) begin up = ua / ub; m_lo = up[31:0]; up = ua % ub; m_hi = up[31:0]; end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic sflush, input int intr_at, input logic [3:0] intr_op,
                            input logic intr_flush);
    int n;
    logic [31:0] old_hi, old_lo;
    n = sflush ? 0 : model_cycles(op);
    old_hi = m_hi;
    old_lo = m_lo;
    Start = 1'b1; MDUOp = op; SrcA = a; SrcB = b; Flush = sflush;
    tick();
    Start = 1'b0; MDUOp = 4'd0; Flush = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("busy_run", {31'd0, Busy}, 32'd1);
      chk("hi_hold", HI, old_hi);
      chk("lo_hold", LO, old_lo);
      if (i == intr_at) begin
        Start = 1'b1; MDUOp = intr_op; SrcA = 32'h1234; Flush = intr_flush;
      end
      tick();
      Start = 1'b0; MDUOp = 4'd0; Flush = 1'b0;
    end
    if (!sflush) model_apply(op, a, b);
    chk("busy_done", {31'd0, Busy}, 32'd0);
    chk("hi_commit", HI, m_hi);
    chk("lo_commit", LO, m_lo);
  endtask

  task automatic run_single(input logic [3:0] op, input logic [31:0] a, input logic fl);
    Start = 1'b1; MDUOp = op; SrcA = a; Flush = fl;
    tick();
    Start = 1'b0; MDUOp = 4'd0; Flush = 1'b0;
    if (!fl) model_apply(op, a, 32'd0);
    chk("busy_single", {31'd0, Busy}, 32'd0);
    chk("hi_single", HI, m_hi);
    chk("lo_single", LO, m_lo);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          sel;

    // Reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);

    // 1: signed multiply
    run_muldiv(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, -1, 4'd0, 1'b0);
    chk("t1_hi", HI, 32'hFFFF_FFFF);
    chk("t1_lo", LO, 32'hFFFF_FFFA);

    // 2: unsigned multiply
    run_muldiv(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, -1, 4'd0, 1'b0);
    chk("t2_hi", HI, 32'h0000_0001);
    chk("t2_lo", LO, 32'hFFFF_FFFE);

    // 3: signed divide, then unsigned divide by zero keeps HI/LO
    run_muldiv(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, 4'd0, 1'b0);
    chk("t3_lo", LO, 32'hFFFF_FFFD);
    chk("t3_hi", HI, 32'hFFFF_FFFF);
    run_muldiv(4'd4, 32'd7, 32'd0, 1'b0, -1, 4'd0, 1'b0);
    chk("t3_dz_hi", HI, 32'hFFFF_FFFF);
    chk("t3_dz_lo", LO, 32'hFFFF_FFFD);

    // Overflow corner of signed divide
    run_muldiv(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 4'd0, 1'b0);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'h0000_0000);

    // 4: Start+MTLO during RUN is ignored; Flush during RUN does not cancel
    run_muldiv(4'd1, 32'd100, 32'hFFFF_FFF6, 1'b0, 1, 4'd6, 1'b0);
    chk("t4_lo", LO, 32'hFFFF_FC18);
    run_muldiv(4'd2, 32'd9, 32'd9, 1'b0, 2, 4'd1, 1'b1);
    chk("flush_run_lo", LO, 32'd81);

    // Start together with Flush is dropped entirely
    run_muldiv(4'd1, 32'd5, 32'd5, 1'b1, -1, 4'd0, 1'b0);

    // 5: MTHI with Flush ignored, without Flush written
    run_single(4'd5, 32'hDEAD_BEEF, 1'b1);
    chk("t5_flush_hi", HI, 32'h0000_0000);
    run_single(4'd5, 32'hDEAD_BEEF, 1'b0);
    chk("t5_hi", HI, 32'hDEAD_BEEF);
    run_single(4'd6, 32'h0BAD_F00D, 1'b0);
    run_single(4'd0, 32'h1111_1111, 1'b0);
    run_single(4'd12, 32'h2222_2222, 1'b0);

    // 6: reset in RUN cycle 4 aborts the divide
    Start = 1'b1; MDUOp = 4'd3; SrcA = 32'd1000; SrcB = 32'd7;
    tick();
    Start = 1'b0; MDUOp = 4'd0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_busy", {31'd0, Busy}, 32'd1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("t6_busy_rst", {31'd0, Busy}, 32'd0);
    chk("t6_hi_rst", HI, 32'd0);
    chk("t6_lo_rst", LO, 32'd0);
    for (int i = 0; i < DC + 2; i++) tick();
    chk("t6_busy_late", {31'd0, Busy}, 32'd0);
    chk("t6_hi_late", HI, 32'd0);
    chk("t6_lo_late", LO, 32'd0);

    // Randomized ops against the model
    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 8);
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (sel == 7) rop = 4'd9;
      else if (sel == 8) rop = 4'd15;
      else rop = 4'(sel);
      if (rop >= 4'd1 && rop <= 4'd4)
        run_muldiv(rop, ra, rb, ($urandom_range(0, 7) == 0), -1, 4'd0, 1'b0);
      else
        run_single(rop, ra, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
